tea_cbc_ctrl: RTL and testbench

TEA_CBC_CTRL -- requirements
Module: tea_cbc_ctrl

---
 rtl/tea_pkg.sv | 7 +
 rtl/tea_byte_ser.sv | 34 +++
 rtl/tea_cbc_ctrl.sv | 101 ++++++++++
 tb/tb_tea_cbc_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// tea_pkg: shared constants and FSM state type for the TEA-CBC byte controller
package tea_pkg;
  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;
  localparam int BLOCK_W = 64;
  localparam int BYTES_PER_BLOCK = 8;
  typedef enum logic [1:0] {COLLECT, LAUNCH, WAIT, EMIT} state_t;
endpackage

// File: rtl/tea_byte_ser.sv
// tea_byte_ser: serializes a 64-bit word MSB-first into bytes over valid/ready
module tea_byte_ser
  import tea_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BLOCK_W-1:0] data,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               last
);
  logic [BLOCK_W-1:0] shreg;
  logic [2:0]         cnt;
  assign out_data = shreg[BLOCK_W-1 -: 8];
  assign last = out_valid && out_ready && cnt == 3'd7;
  // shift out one byte per accepted transfer; drop valid after the eighth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      shreg     <= data;
      cnt       <= '0;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      shreg <= {shreg[BLOCK_W-9:0], 8'h00};
      cnt   <= cnt + 3'd1;
      if (cnt == 3'd7) out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/tea_cbc_ctrl.sv
// tea_cbc_ctrl: packs plaintext bytes into 64-bit blocks, CBC-chains them through an external TEA core and streams ciphertext bytes
module tea_cbc_ctrl
  import tea_pkg::*;
#(
  parameter int ENC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        iv_load,
  input  logic [63:0] iv,
  output logic        enc_start,
  output logic [31:0] enc_v1,
  output logic [31:0] enc_v2,
  input  logic        enc_done,
  input  logic [31:0] enc_v1_out,
  input  logic [31:0] enc_v2_out,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        error
);
  localparam int TW = $clog2(ENC_TIMEOUT + 1);
  state_t             state;
  logic [2:0]         bcnt;
  logic [BLOCK_W-1:0] block, chain, nxt_block;
  logic [TW-1:0]      tcnt;
  logic               done_q, take, fire, ser_last;
  assign in_ready = state == COLLECT;
  assign busy     = state != COLLECT;
  assign take     = in_valid && in_ready;
  assign fire     = state == WAIT && enc_done && !done_q;
  // byte k lands at bits [63-8k -: 8], so the first byte is the block MSB
  always_comb begin
    nxt_block = block;
    nxt_block[{~bcnt, 3'b000} +: 8] = in_data;
  end
  // block FSM; done_q tracks enc_done so only a fresh 0->1 edge completes WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= COLLECT;
      bcnt      <= '0;
      block     <= '0;
      chain     <= '0;
      tcnt      <= '0;
      done_q    <= 1'b0;
      enc_start <= 1'b0;
      enc_v1    <= '0;
      enc_v2    <= '0;
      error     <= 1'b0;
    end else begin
      done_q    <= enc_done;
      enc_start <= 1'b0;
      case (state)
        COLLECT: begin
          if (iv_load && bcnt == 3'd0) chain <= iv;
          if (take) begin
            block <= nxt_block;
            bcnt  <= bcnt + 3'd1;
            if (bcnt == 3'd7) begin
              state     <= LAUNCH;
              enc_start <= 1'b1;
              enc_v1    <= nxt_block[63:32] ^ chain[63:32];
              enc_v2    <= nxt_block[31:0] ^ chain[31:0];
            end
          end
        end
        LAUNCH: begin
          state <= WAIT;
          tcnt  <= '0;
        end
        WAIT: begin
          if (fire) begin
            chain <= {enc_v1_out, enc_v2_out};
            state <= EMIT;
          end else if (tcnt == TW'(ENC_TIMEOUT - 1)) begin
            error <= 1'b1;
            state <= COLLECT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        EMIT: state <= ser_last ? COLLECT : EMIT;
        default: state <= COLLECT;
      endcase
    end
  end
  tea_byte_ser u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (fire),
    .data     ({enc_v1_out, enc_v2_out}),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .last     (ser_last)
  );
endmodule

// File: tb/tb_tea_cbc_ctrl.sv
// tb_tea_cbc_ctrl: randomized self-checking bench with a TEA/CBC reference model
module tb_tea_cbc_ctrl;
  import tea_pkg::TEA_DELTA;
  logic        clk = 0, reset = 1;
  logic [7:0]  in_data = 0;
  logic        in_valid = 0, in_ready;
  logic        iv_load = 0;
  logic [63:0] iv = 0;
  logic        enc_start;
  logic [31:0] enc_v1, enc_v2;
  logic        enc_done = 0;
  logic [31:0] enc_v1_out = 0, enc_v2_out = 0;
  logic [7:0]  out_data;
  logic        out_valid, out_ready = 0, busy, error;
  int checks = 0, errors = 0;
  logic [63:0] chain_m = 0;

  tea_cbc_ctrl #(.ENC_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .iv_load(iv_load), .iv(iv), .enc_start(enc_start), .enc_v1(enc_v1), .enc_v2(enc_v2),
    .enc_done(enc_done), .enc_v1_out(enc_v1_out), .enc_v2_out(enc_v2_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] tea_enc(input logic [63:0] p);
    logic [31:0] v0, v1, sum;
    v0 = p[63:32]; v1 = p[31:0]; sum = 0;
    for (int i = 0; i < 32; i++) begin
      sum += TEA_DELTA;
      v0 += (v1 << 4) ^ (v1 + sum) ^ (v1 >> 5);
      v1 += (v0 << 4) ^ (v0 + sum) ^ (v0 >> 5);
    end
    return {v0, v1};
  endfunction

  task automatic send_block(input logic [63:0] blk, input bit ld, input logic [63:0] ivv, input int junk_k);
    logic [63:0] x;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1; in_data = blk[63-8*k -: 8];
      iv_load = (k == 0 && ld) || k == junk_k;
      iv = (k == 0) ? ivv : {$urandom, $urandom};
      if (k == 0 && ld) chain_m = ivv;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready byte%0d: got %b want 1", k, in_ready); end
      @(negedge clk);
    end
    in_valid = 0; iv_load = 0;
    x = blk ^ chain_m;
    checks++; if (enc_start !== 1'b1) begin errors++; $display("FAIL enc_start launch: got %b want 1", enc_start); end
    checks++; if ({enc_v1, enc_v2} !== x) begin errors++; $display("FAIL enc_v launch: got %h%h want %h", enc_v1, enc_v2, x); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL busy launch: in_ready %b busy %b want 0 1", in_ready, busy); end
    @(negedge clk);
    checks++; if (enc_start !== 1'b0) begin errors++; $display("FAIL enc_start pulse: got %b want 0", enc_start); end
  endtask

  task automatic respond(input logic [63:0] blk, input int lat, input bit hold);
    logic [63:0] ct;
    ct = tea_enc(blk ^ chain_m);
    for (int i = 0; i < lat; i++) begin
      checks++; if (out_valid !== 1'b0 || {enc_v1, enc_v2} !== (blk ^ chain_m)) begin errors++; $display("FAIL wait hold: out_valid %b enc_v %h%h", out_valid, enc_v1, enc_v2); end
      @(negedge clk);
    end
    enc_done = 1; {enc_v1_out, enc_v2_out} = ct;
    @(negedge clk);
    if (!hold) enc_done = 0;
    chain_m = ct;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL out_valid after done: got %b want 1", out_valid); end
  endtask

  task automatic collect(input logic [63:0] ct, input bit alt);
    int j = 0, cyc = 0;
    bit r, v;
    while (j < 8 && cyc < 200) begin
      v = out_valid;
      checks++;
      if (out_valid !== 1'b1 || out_data !== ct[63-8*j -: 8]) begin
        errors++; $display("FAIL out byte%0d: valid %b data %h want 1 %h", j, out_valid, out_data, ct[63-8*j -: 8]);
      end
      r = alt ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      out_ready = r;
      @(negedge clk);
      if (r && v) j++;
      cyc++;
    end
    out_ready = 0;
    checks++; if (j != 8) begin errors++; $display("FAIL collect timeout: got %0d bytes want 8", j); end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post emit: valid %b busy %b want 0 0", out_valid, busy); end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if ({in_ready, enc_start, enc_v1, enc_v2, out_valid, out_data, busy, error} !== {1'b1, 1'b0, 64'h0, 1'b0, 8'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s: in_ready %b start %b v %h%h ov %b od %h busy %b err %b", tag, in_ready, enc_start, enc_v1, enc_v2, out_valid, out_data, busy, error);
    end
  endtask

  task automatic test_reset;
    check_idle("reset values");
  endtask

  task automatic test_zero_vector;
    send_block(64'h0, 1, 64'h0, -1);
    respond(64'h0, 3, 0);
    collect(64'h41ea3a0a94baa940, 0);
    send_block(64'h0, 0, 64'h0, -1);
    checks++; if ({enc_v1, enc_v2} !== 64'h41ea3a0a94baa940) begin errors++; $display("FAIL chain xor: got %h%h want 41ea3a0a94baa940", enc_v1, enc_v2); end
    respond(64'h0, 1, 0);
    collect(chain_m, 1);
  endtask

  task automatic test_iv_load;
    send_block(64'h0, 1, 64'h0123456789ABCDEF, 4);
    checks++; if (enc_v1 !== 32'h01234567 || enc_v2 !== 32'h89ABCDEF) begin errors++; $display("FAIL iv launch: got %h %h want 01234567 89abcdef", enc_v1, enc_v2); end
    respond(64'h0, 2, 0);
    collect(chain_m, 0);
  endtask

  task automatic test_random;
    logic [63:0] blk;
    for (int n = 0; n < 6; n++) begin
      blk = {$urandom, $urandom};
      send_block(blk, 1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(1, 7));
      respond(blk, $urandom_range(0, 10), 0);
      collect(chain_m, 0);
    end
  endtask

  task automatic test_held_done;
    logic [63:0] blk;
    blk = {$urandom, $urandom};
    send_block(blk, 0, 64'h0, -1);
    respond(blk, 2, 1);
    collect(chain_m, 0);
    blk = {$urandom, $urandom};
    send_block(blk, 0, 64'h0, -1);
    for (int i = 0; i < 5; i++) begin
      checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL held done: busy %b out_valid %b want 1 0", busy, out_valid); end
      @(negedge clk);
    end
    enc_done = 0;
    @(negedge clk);
    respond(blk, 0, 0);
    collect(chain_m, 1);
  endtask

  task automatic test_timeout;
    logic [63:0] blk;
    blk = {$urandom, $urandom};
    send_block(blk, 0, 64'h0, -1);
    for (int i = 0; i < 63; i++) begin
      checks++; if (out_valid !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL timeout wait%0d: out_valid %b error %b want 0 0", i, out_valid, error); end
      @(negedge clk);
    end
    checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout early: error %b busy %b want 0 1", error, busy); end
    @(negedge clk);
    checks++; if (error !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL timeout: error %b busy %b ov %b want 1 0 0", error, busy, out_valid); end
    blk = {$urandom, $urandom};
    send_block(blk, 0, 64'h0, -1);
    respond(blk, 4, 0);
    collect(chain_m, 0);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL error sticky: got %b want 1", error); end
  endtask

  task automatic test_reset_in_wait;
    logic [63:0] blk;
    blk = {$urandom, $urandom};
    send_block(blk, 0, 64'h0, -1);
    repeat (2) @(negedge clk);
    reset = 1;
    #1 check_idle("reset in wait");
    #1 reset = 0;
    chain_m = 0;
    enc_done = 1; {enc_v1_out, enc_v2_out} = tea_enc(blk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL late done: out_valid %b busy %b want 0 0", out_valid, busy); end
    end
    enc_done = 0;
    @(negedge clk);
    send_block(64'h0, 0, 64'h0, -1);
    respond(64'h0, 1, 0);
    collect(64'h41ea3a0a94baa940, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    test_reset();
    test_zero_vector();
    test_iv_load();
    test_random();
    test_held_done();
    test_timeout();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
